mult_seq_ctrl: RTL

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_abs32.sv | 11 +
 rtl/mult_seq_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential multiplier controller.
package mult_pkg;
   localparam int OP_W           = 32;
   localparam int PROD_W         = 64;
   localparam int TIMEOUT_CYCLES = 96;
   localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      RUN,
      HOLD
   } state_t;
endpackage

// File: rtl/mult_abs32.sv
// 32-bit two's complement magnitude with sign; 0x80000000 maps to itself (valid unsigned).
module mult_abs32
   import mult_pkg::*;
(
   input  logic [OP_W-1:0] i_val,
   output logic [OP_W-1:0] o_mag,
   output logic            o_sign
);
   assign o_sign = i_val[OP_W-1];
   assign o_mag  = o_sign ? (~i_val + OP_W'(1)) : i_val;
endmodule

// File: rtl/mult_seq_ctrl.sv
// Handshaked controller around an iterative multiplier, with a RUN-phase timeout.
// Optional MULT_SIGNED_EN: two's complement operands via magnitude + sign fix-up.
module mult_seq_ctrl
   import mult_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out_product,
   output logic              out_err,
   output logic [OP_W-1:0]   mul_a,
   output logic [OP_W-1:0]   mul_b,
   output logic              mul_start,
   output logic              mul_clear,
   input  logic [PROD_W-1:0] mul_product,
   input  logic              mul_done
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t              r_state, w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [OP_W-1:0]     r_a, r_b;
   logic [PROD_W-1:0]   r_product;
   logic                r_err;
   logic [OP_W-1:0]     w_op_a, w_op_b;
   logic [PROD_W-1:0]   w_prod_fix;
   logic                w_timeout;

`ifdef MULT_SIGNED_EN
   logic [OP_W-1:0] w_mag_a, w_mag_b;
   logic            w_sgn_a, w_sgn_b;
   logic            r_neg;

   mult_abs32 u_abs_a (.i_val(in_a), .o_mag(w_mag_a), .o_sign(w_sgn_a));
   mult_abs32 u_abs_b (.i_val(in_b), .o_mag(w_mag_b), .o_sign(w_sgn_b));

   assign w_op_a     = w_mag_a;
   assign w_op_b     = w_mag_b;
   assign w_prod_fix = r_neg ? (~mul_product + PROD_W'(1)) : mul_product;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_neg <= 1'b0;
      else if (r_state == IDLE && in_valid)
         r_neg <= w_sgn_a ^ w_sgn_b;
   end
`else
   assign w_op_a     = in_a;
   assign w_op_b     = in_b;
   assign w_prod_fix = mul_product;
`endif

   assign w_timeout   = (r_cnt == CNT_LAST);
   assign in_ready    = (r_state == IDLE);
   assign out_valid   = (r_state == HOLD);
   assign mul_start   = (r_state == RUN);
   // Multiplier stays cleared for the whole of our own reset, not just CLEAR.
   assign mul_clear   = reset | (r_state == CLEAR);
   assign mul_a       = r_a;
   assign mul_b       = r_b;
   assign out_product = r_product;
   assign out_err     = r_err;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)               w_next = CLEAR;
         CLEAR:                               w_next = RUN;
         RUN:     if (mul_done || w_timeout)  w_next = HOLD;
         HOLD:    if (out_ready)              w_next = IDLE;
         default:                             w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_product <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: if (in_valid) begin
               r_a <= w_op_a;
               r_b <= w_op_b;
            end
            CLEAR: r_cnt <= '0;
            RUN: begin
               // Done has priority over a timeout landing on the same cycle.
               if (mul_done) begin
                  r_product <= w_prod_fix;
                  r_err     <= 1'b0;
               end else if (w_timeout) begin
                  r_product <= '0;
                  r_err     <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
